// File: rtl/laser_point_feeder_if.sv
// laser_point_feeder_if: host table/run port plus LASER engine port of the feeder
interface laser_point_feeder_if;
  logic       ld_en;
  logic [5:0] ld_addr;
  logic [3:0] ld_x, ld_y;
  logic       start;
  logic       laser_rst;
  logic [3:0] x, y;
  logic [3:0] c1x, c1y, c2x, c2y;
  logic       done;
  logic       busy;
  logic [5:0] score;
  logic       score_valid, timed_out;
  modport master (
    output ld_en, ld_addr, ld_x, ld_y, start, c1x, c1y, c2x, c2y, done,
    input  laser_rst, x, y, busy, score, score_valid, timed_out
  );
  modport slave (
    input  ld_en, ld_addr, ld_x, ld_y, start, c1x, c1y, c2x, c2y, done,
    output laser_rst, x, y, busy, score, score_valid, timed_out
  );
endinterface

// File: rtl/laser_point_feeder.sv
// laser_point_feeder: streams a point table to LASER, then scores its two circles
module laser_point_feeder #(
  parameter int NPTS        = 40,
  parameter int TIMEOUT_CYC = 4095,
  parameter int R2          = 16
) (
  input logic                 clk,
  input logic                 rst,
  laser_point_feeder_if.slave bus
);
  typedef enum logic [2:0] {S_IDLE, S_PULSE, S_STREAM, S_WAIT, S_SCORE, S_REPORT} state_t;
  localparam logic [5:0]  LAST = 6'(NPTS - 1);
  localparam logic [5:0]  N6   = 6'(NPTS);
  localparam logic [11:0] TO   = 12'(TIMEOUT_CYC);
  localparam logic [8:0]  R2_9 = 9'(R2);
  state_t      state_q, state_d;
  logic [5:0]  idx_q, idx_d, acc_q, acc_d, score_q, score_d, idx_nx;
  logic [11:0] wcnt_q, wcnt_d;
  logic [3:0]  c1x_q, c1y_q, c2x_q, c2y_q, c1x_d, c1y_d, c2x_d, c2y_d;
  logic [3:0]  x_q, y_q, x_d, y_d;
  logic        laser_rst_q, laser_rst_d, busy_q, busy_d;
  logic        score_valid_q, score_valid_d, timed_out_q, timed_out_d;
  logic [3:0]  tx_q [NPTS];
  logic [3:0]  ty_q [NPTS];
  logic        wr, cov;
  function automatic logic [7:0] sq_diff(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] d;
    d = a > b ? a - b : b - a;
    return {4'd0, d} * {4'd0, d};
  endfunction
  function automatic logic in_circle(input logic [3:0] px, input logic [3:0] py,
                                     input logic [3:0] cx, input logic [3:0] cy);
    return ({1'b0, sq_diff(px, cx)} + {1'b0, sq_diff(py, cy)}) <= R2_9;
  endfunction
  assign wr     = state_q == S_IDLE && bus.ld_en && bus.ld_addr < N6;
  assign idx_nx = idx_q + 6'd1;
  assign cov    = in_circle(tx_q[idx_q], ty_q[idx_q], c1x_q, c1y_q) |
                  in_circle(tx_q[idx_q], ty_q[idx_q], c2x_q, c2y_q);
  // point table write port; contents deliberately survive rst
  always_ff @(posedge clk) begin
    if (wr) begin
      tx_q[bus.ld_addr] <= bus.ld_x;
      ty_q[bus.ld_addr] <= bus.ld_y;
    end
  end
  // state register and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      idx_q         <= '0;
      wcnt_q        <= '0;
      acc_q         <= '0;
      score_q       <= '0;
      c1x_q         <= '0;
      c1y_q         <= '0;
      c2x_q         <= '0;
      c2y_q         <= '0;
      x_q           <= '0;
      y_q           <= '0;
      laser_rst_q   <= 1'b0;
      busy_q        <= 1'b0;
      score_valid_q <= 1'b0;
      timed_out_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      wcnt_q        <= wcnt_d;
      acc_q         <= acc_d;
      score_q       <= score_d;
      c1x_q         <= c1x_d;
      c1y_q         <= c1y_d;
      c2x_q         <= c2x_d;
      c2y_q         <= c2y_d;
      x_q           <= x_d;
      y_q           <= y_d;
      laser_rst_q   <= laser_rst_d;
      busy_q        <= busy_d;
      score_valid_q <= score_valid_d;
      timed_out_q   <= timed_out_d;
    end
  end
  // next-state: DONE outranks the timeout limit in WAIT
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   state_d = bus.start ? S_PULSE : S_IDLE;
      S_PULSE:  state_d = S_STREAM;
      S_STREAM: state_d = idx_q == LAST ? S_WAIT : S_STREAM;
      S_WAIT:   state_d = bus.done ? S_SCORE : (wcnt_q == TO ? S_REPORT : S_WAIT);
      S_SCORE:  state_d = idx_q == LAST ? S_REPORT : S_SCORE;
      S_REPORT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end
  // outputs and datapath for the upcoming cycle; X/Y and strobes default low
  always_comb begin
    idx_d         = idx_q;
    wcnt_d        = wcnt_q;
    acc_d         = acc_q;
    score_d       = score_q;
    timed_out_d   = timed_out_q;
    c1x_d         = c1x_q;
    c1y_d         = c1y_q;
    c2x_d         = c2x_q;
    c2y_d         = c2y_q;
    x_d           = '0;
    y_d           = '0;
    laser_rst_d   = 1'b0;
    score_valid_d = 1'b0;
    busy_d        = state_d != S_IDLE;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          laser_rst_d = 1'b1;
          timed_out_d = 1'b0;
          idx_d       = '0;
        end
      end
      S_PULSE: begin
        x_d = tx_q[0];
        y_d = ty_q[0];
      end
      S_STREAM: begin
        if (idx_q == LAST) wcnt_d = '0;
        else begin
          idx_d = idx_nx;
          x_d   = tx_q[idx_nx];
          y_d   = ty_q[idx_nx];
        end
      end
      S_WAIT: begin
        if (bus.done) begin
          c1x_d = bus.c1x;
          c1y_d = bus.c1y;
          c2x_d = bus.c2x;
          c2y_d = bus.c2y;
          idx_d = '0;
          acc_d = '0;
        end else if (wcnt_q == TO) begin
          timed_out_d   = 1'b1;
          score_d       = '0;
          score_valid_d = 1'b1;
        end else wcnt_d = wcnt_q + 12'd1;
      end
      S_SCORE: begin
        acc_d = acc_q + {5'd0, cov};
        idx_d = idx_nx;
        if (idx_q == LAST) begin
          score_d       = acc_q + {5'd0, cov};
          score_valid_d = 1'b1;
        end
      end
      default: ;
    endcase
  end
  assign bus.laser_rst   = laser_rst_q;
  assign bus.x           = x_q;
  assign bus.y           = y_q;
  assign bus.busy        = busy_q;
  assign bus.score       = score_q;
  assign bus.score_valid = score_valid_q;
  assign bus.timed_out   = timed_out_q;
endmodule

// File: tb/tb_laser_point_feeder.sv
// tb_laser_point_feeder: directed and randomized runs scored against a geometric reference model
module tb_laser_point_feeder;
  localparam int NPTS = 40, TIMEOUT_CYC = 4095, R2 = 16;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0, failures = 0;
  int mx [NPTS];
  int my [NPTS];
  int ax, ay, bx, by;
  laser_point_feeder_if bus();
  laser_point_feeder #(.NPTS(NPTS), .TIMEOUT_CYC(TIMEOUT_CYC), .R2(R2)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  function automatic bit in_c(input int px, input int py, input int cx, input int cy);
    return (px - cx) * (px - cx) + (py - cy) * (py - cy) <= R2;
  endfunction
  function automatic int model_score(input int c1x, input int c1y, input int c2x, input int c2y);
    int n = 0;
    for (int i = 0; i < NPTS; i++) n += (in_c(mx[i], my[i], c1x, c1y) || in_c(mx[i], my[i], c2x, c2y)) ? 1 : 0;
    return n;
  endfunction
  task automatic load(input int a, input int px, input int py);
    bus.ld_en = 1'b1;
    bus.ld_addr = 6'(a);
    bus.ld_x = 4'(px);
    bus.ld_y = 4'(py);
    tick;
    bus.ld_en = 1'b0;
    if (a < NPTS) begin
      mx[a] = px;
      my[a] = py;
    end
  endtask
  task automatic quiet(input int n);
    int c = 0;
    repeat (n) begin
      if (bus.score_valid === 1'b1) c++;
      tick;
    end
    chk("no_sv_after_abort", c, 0);
  endtask
  task automatic run(input int done_at, input int c1x, input int c1y, input int c2x, input int c2y,
                     input bit noise, input int rst_at, input bit co_load);
    int exp_score, exp_off, first, a;
    bus.start = 1'b1;
    if (co_load) begin
      a = $urandom_range(0, NPTS - 1);
      bus.ld_en = 1'b1;
      bus.ld_addr = 6'(a);
      bus.ld_x = 4'($urandom);
      bus.ld_y = 4'($urandom);
      mx[a] = int'(bus.ld_x);
      my[a] = int'(bus.ld_y);
    end
    chk("idle_busy", bus.busy, 0);
    tick;
    bus.start = 1'b0;
    bus.ld_en = 1'b0;
    chk("pulse_laser_rst", bus.laser_rst, 1);
    chk("pulse_busy", bus.busy, 1);
    chk("start_clears_timeout", bus.timed_out, 0);
    tick;
    for (int k = 0; k < NPTS; k++) begin
      chk($sformatf("stream_xy[%0d]", k), {bus.x, bus.y}, mx[k] * 16 + my[k]);
      if (k == 0) chk("laser_rst_one_cycle", bus.laser_rst, 0);
      if (k == rst_at) begin
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("abort_busy", bus.busy, 0);
        chk("abort_xy", {bus.x, bus.y}, 0);
        chk("abort_sv", bus.score_valid, 0);
        return;
      end
      if (noise) begin
        bus.start = 1'b1;
        bus.ld_en = 1'b1;
        bus.ld_addr = 6'($urandom);
        bus.ld_x = 4'($urandom);
        bus.ld_y = 4'($urandom);
        bus.done = 1'b1;
        bus.c1x = 4'($urandom);
        bus.c2y = 4'($urandom);
      end
      tick;
    end
    bus.start = 1'b0;
    bus.ld_en = 1'b0;
    bus.done = 1'b0;
    chk("wait_xy_zero", {bus.x, bus.y}, 0);
    exp_score = done_at >= 0 ? model_score(c1x, c1y, c2x, c2y) : 0;
    exp_off = done_at >= 0 ? done_at + NPTS + 1 : TIMEOUT_CYC + 1;
    first = -1;
    for (int off = 0; off <= exp_off + 3; off++) begin
      if (bus.score_valid === 1'b1) begin
        first = off;
        break;
      end
      bus.done = off == done_at;
      bus.c1x = bus.done ? 4'(c1x) : 4'($urandom);
      bus.c1y = bus.done ? 4'(c1y) : 4'($urandom);
      bus.c2x = bus.done ? 4'(c2x) : 4'($urandom);
      bus.c2y = bus.done ? 4'(c2y) : 4'($urandom);
      tick;
    end
    bus.done = 1'b0;
    chk("sv_latency", first, exp_off);
    if (first >= 0) begin
      chk("score", bus.score, exp_score);
      chk("timed_out", bus.timed_out, done_at < 0);
      chk("report_busy", bus.busy, 1);
      tick;
      chk("sv_one_cycle", bus.score_valid, 0);
      chk("busy_falls", bus.busy, 0);
      chk("score_hold", bus.score, exp_score);
    end
  endtask
  initial begin
    int n1, n2, px, py;
    bus.ld_en = 1'b0;
    bus.ld_addr = '0;
    bus.ld_x = '0;
    bus.ld_y = '0;
    bus.start = 1'b0;
    bus.done = 1'b0;
    bus.c1x = '0;
    bus.c1y = '0;
    bus.c2x = '0;
    bus.c2y = '0;
    rst = 1'b1;
    tick;
    tick;
    chk("rst_laser_rst", bus.laser_rst, 0);
    chk("rst_xy", {bus.x, bus.y}, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_score", bus.score, 0);
    chk("rst_sv", bus.score_valid, 0);
    chk("rst_timed_out", bus.timed_out, 0);
    rst = 1'b0;
    tick;
    for (int i = 0; i < NPTS; i++) load(i, 5, 5);
    run(3, 5, 5, 0, 0, 1'b0, -1, 1'b0);
    for (int i = 0; i < NPTS; i++) load(i, 15, 15);
    load(0, 12, 8);
    load(1, 8, 4);
    load(2, 11, 11);
    load(3, 12, 9);
    load(4, 15, 15);
    load(5, 4, 8);
    run(0, 8, 8, 0, 0, 1'b0, -1, 1'b0);
    load(0, 6, 6);
    load(1, 5, 7);
    load(2, 7, 5);
    n1 = 3;
    n2 = 0;
    for (int i = 3; i < NPTS; i++) begin
      do begin
        px = $urandom_range(0, 15);
        py = $urandom_range(0, 15);
      end while (!(n1 < 20 ? in_c(px, py, 4, 4) && !in_c(px, py, 8, 8) : in_c(px, py, 8, 8) && !in_c(px, py, 4, 4)));
      if (n1 < 20) n1++; else n2++;
      load(i, px, py);
    end
    run(5, 4, 4, 8, 8, 1'b1, -1, 1'b0);
    for (int i = 0; i < 4; i++) load($urandom_range(NPTS, 63), $urandom_range(0, 15), $urandom_range(0, 15));
    run(1, 4, 4, 8, 8, 1'b0, -1, 1'b0);
    repeat (3) begin
      for (int i = 0; i < NPTS; i++) load(i, $urandom_range(0, 15), $urandom_range(0, 15));
      ax = $urandom_range(0, 15);
      ay = $urandom_range(0, 15);
      bx = $urandom_range(0, 15);
      by = $urandom_range(0, 15);
      run($urandom_range(0, 8), ax, ay, bx, by, 1'b1, -1, 1'b1);
    end
    run(2, ax, ay, bx, by, 1'b0, 17, 1'b0);
    quiet(60);
    run(2, ax, ay, bx, by, 1'b0, -1, 1'b0);
    run(-1, 0, 0, 0, 0, 1'b1, -1, 1'b0);
    tick;
    tick;
    chk("timeout_sticky", bus.timed_out, 1);
    chk("timeout_idle_busy", bus.busy, 0);
    run(TIMEOUT_CYC, bx, by, ax, ay, 1'b0, -1, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
